// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive pair.
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/bit_counter.sv
// Modulo-WIDTH up-counter with synchronous clear and terminal-count flag.
module bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out transmitter: shifts a WIDTH-bit word out MSB first,
// chaining frames back-to-back when a new word is offered on the last bit.
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last
);

    localparam int CW = $clog2(WIDTH);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;

    // Handshake: a word transfers on a rising edge where din_valid and
    // din_ready are both high; din_ready depends on registered state only.
    assign accept = din_valid && din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (tc && !accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                din_ready  = tc;
                sout       = shreg[WIDTH-1];
                sout_valid = 1'b1;
                sout_last  = tc;
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= din;
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    // Clearing on accept restarts a chained frame; plain wrap handles the return to IDLE.
    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == SHIFT),
        .cnt   (cnt),
        .tc    (tc)
    );

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: directed frames plus random traffic against a
// bit-queue model and a loopback shift-left receiver.
module tb_serial_tx_piso;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;

    int n_vec = 0;
    int n_err = 0;

    // Model: bits still to appear on sout (front = bit shown this cycle).
    logic         exp_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] rx = '0;

    serial_tx_piso #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_sout_valid", 32'(sout_valid), 32'd0);
        chk("rst_sout_last", 32'(sout_last), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
    endtask

    task automatic check_outputs();
        logic e_valid;
        e_valid = (exp_q.size() > 0);
        chk("sout_valid", 32'(sout_valid), 32'(e_valid));
        chk("sout", 32'(sout), e_valid ? 32'(exp_q[0]) : 32'd0);
        chk("sout_last", 32'(sout_last), 32'(exp_q.size() == 1));
        chk("din_ready", 32'(din_ready), 32'(exp_q.size() <= 1));
        if (sout_valid) begin
            rx = {rx[W-2:0], sout};
            if (sout_last) begin
                if (word_q.size() == 0) chk("loopback_unexpected", 32'd1, 32'd0);
                else chk("loopback", 32'(rx), 32'(word_q.pop_front()));
            end
        end
    endtask

    // Called at a falling edge: check this cycle, drive inputs, advance model.
    task automatic step(input logic v, input logic [W-1:0] d);
        logic acc;
        check_outputs();
        din_valid = v;
        din       = d;
        acc = v && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
            word_q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    // Called at a falling edge; reset lands mid-cycle to show it is asynchronous.
    task automatic do_reset(input int cycles);
        #2;
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = W'($urandom);
        #1;
        check_reset_outputs();
        exp_q.delete();
        word_q.delete();
        rx = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        din_valid = 1'b1;
        din       = 8'h5A;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;

        // Single frame.
        step(1'b1, 8'hA5);
        idle(W + 2);

        // Back-to-back: second word offered during the last bit.
        step(1'b1, 8'hA5);
        for (int i = 0; i < W - 1; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        idle(W + 2);

        // din changes (with din_valid high) while the frame is in flight.
        step(1'b1, 8'hF0);
        for (int i = 0; i < W - 1; i++) step(1'b1, 8'h0F);
        step(1'b0, 8'h0F);
        idle(W + 1);

        // Reset in cycle 3 of a frame, then a clean frame.
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check_outputs();
        do_reset(2);
        step(1'b1, 8'h81);
        idle(W + 2);

        // Loopback word.
        step(1'b1, 8'hC3);
        idle(W + 2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, W'($urandom));
        end
        idle(W + 2);
        chk("drain_words", 32'(word_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
